multiplier_nxm: RTL and testbench

Parametrised sequential shift-add multiplier that succeeds the fixed square N-bit multiplier. It takes independent operand widths, a per-operation signed/unsigned mode and a start edge-detect handshake. An optional sequential binary-to-BCD converter drives display logic. It sits between operand registers and the seven-segment/BCD display path, one result per start pulse.

---
 rtl/multiplier_nxm_if.sv | 39 +++
 rtl/multiplier_nxm.sv | 182 ++++++++++++++++++
 tb/tb_multiplier_nxm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_nxm_if.sv
// Operand/result bundle for multiplier_nxm; bcd and bcd_neg exist only when
// MULT_BCD_EN is defined.
interface multiplier_nxm_if #(
  parameter int NA = 5,
  parameter int NB = 5
);
  localparam int W = NA + NB;
`ifdef MULT_BCD_EN
  localparam int D = (W / 3) + 1;
`endif

  logic          start;
  logic          signed_mode;
  logic [NA-1:0] a_in;
  logic [NB-1:0] b_in;
  logic [W-1:0]  out;
  logic          busy;
  logic          finish;
`ifdef MULT_BCD_EN
  logic [4*D-1:0] bcd;
  logic           bcd_neg;
`endif

  modport master (
    output start, signed_mode, a_in, b_in,
`ifdef MULT_BCD_EN
    input  bcd, bcd_neg,
`endif
    input  out, busy, finish
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
`ifdef MULT_BCD_EN
    output bcd, bcd_neg,
`endif
    output out, busy, finish
  );
endinterface

// File: rtl/multiplier_nxm.sv
// Sequential NAxNB shift-add multiplier with signed/unsigned mode and start edge detect.
// Define MULT_BCD_EN to add the double-dabble stage driving bcd/bcd_neg.
//
// state  | meaning
// IDLE   | after reset, waiting for a start edge
// MULT   | NB shift-add iterations on magnitudes
// FIX    | apply result sign
// BCD    | W double-dabble steps (MULT_BCD_EN only)
// DONE   | result held, finish=1, waiting for a start edge
module multiplier_nxm #(
  parameter int NA = 5,
  parameter int NB = 5
) (
  input logic             clk,
  input logic             reset,
  multiplier_nxm_if.slave bus
);
  localparam int W = NA + NB;
`ifdef MULT_BCD_EN
  localparam int D = (W / 3) + 1;
  localparam int CNT_MAX = W;
`else
  localparam int CNT_MAX = NB;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_FIX,
    S_BCD,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic          start_q;
  logic          launch;
  logic [NA-1:0] mcand, a_mag;
  logic [NB-1:0] mplier, b_mag;
  logic [W:0]    acc, acc_nx;
  logic [NA:0]   acc_sum;
  logic [CW-1:0] cnt;
  logic          neg;
  logic [W-1:0]  fix_val;
  logic [W-1:0]  out_r;
  logic          busy_r, finish_r;
  logic          ld_op, do_mult, do_fix, done_set;
`ifdef MULT_BCD_EN
  logic             do_bcd;
  logic [W-1:0]     res, bin_sh;
  logic [4*D-1:0]   bcd_work, bcd_r;
  logic             bcd_neg_r;
  logic [4*D+W-1:0] dab_nx;

  function automatic logic [4*D+W-1:0] dabble(input logic [4*D-1:0] b, input logic [W-1:0] s);
    logic [4*D-1:0] t;
    t = b;
    for (int i = 0; i < D; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t, s} << 1;
  endfunction
`endif

  assign launch = bus.start & ~start_q & ~busy_r;
  assign a_mag  = (bus.signed_mode & bus.a_in[NA-1]) ? -bus.a_in : bus.a_in;
  assign b_mag  = (bus.signed_mode & bus.b_in[NB-1]) ? -bus.b_in : bus.b_in;

  // Upper NA+1 bits take the partial sum; the whole accumulator then shifts right.
  assign acc_sum = acc[W:NB] + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nx  = {acc_sum, acc[NB-1:0]} >> 1;
  assign fix_val = neg ? -acc[W-1:0] : acc[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (launch) state_nx = S_MULT;
      S_MULT:         if (cnt == CW'(1)) state_nx = S_FIX;
`ifdef MULT_BCD_EN
      S_FIX:          state_nx = S_BCD;
      S_BCD:          if (cnt == CW'(1)) state_nx = S_DONE;
`else
      S_FIX:          state_nx = S_DONE;
`endif
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ld_op   = launch && (state == S_IDLE || state == S_DONE);
    do_mult = (state == S_MULT);
    do_fix  = (state == S_FIX);
`ifdef MULT_BCD_EN
    do_bcd   = (state == S_BCD);
    done_set = (state == S_BCD) && (cnt == CW'(1));
`else
    done_set = (state == S_FIX);
`endif
  end

`ifdef MULT_BCD_EN
  always_comb begin
    dab_nx = dabble(bcd_work, bin_sh);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      out_r    <= '0;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
`ifdef MULT_BCD_EN
      res       <= '0;
      bin_sh    <= '0;
      bcd_work  <= '0;
      bcd_r     <= '0;
      bcd_neg_r <= 1'b0;
`endif
    end else begin
      start_q <= bus.start;
      if (ld_op) begin
        mcand    <= a_mag;
        mplier   <= b_mag;
        neg      <= bus.signed_mode & (bus.a_in[NA-1] ^ bus.b_in[NB-1]);
        acc      <= '0;
        cnt      <= CW'(NB);
        busy_r   <= 1'b1;
        finish_r <= 1'b0;
      end
      if (do_mult) begin
        acc    <= acc_nx;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
      if (do_fix) begin
`ifdef MULT_BCD_EN
        // Result stays internal until the BCD digits are ready alongside it.
        res      <= fix_val;
        bin_sh   <= acc[W-1:0];
        bcd_work <= '0;
        cnt      <= CW'(W);
`else
        out_r <= fix_val;
`endif
      end
`ifdef MULT_BCD_EN
      if (do_bcd) begin
        {bcd_work, bin_sh} <= dab_nx;
        cnt                <= cnt - CW'(1);
      end
`endif
      if (done_set) begin
        busy_r   <= 1'b0;
        finish_r <= 1'b1;
`ifdef MULT_BCD_EN
        out_r     <= res;
        bcd_r     <= dab_nx[4*D+W-1:W];
        bcd_neg_r <= neg;
`endif
      end
    end
  end

  assign bus.out    = out_r;
  assign bus.busy   = busy_r;
  assign bus.finish = finish_r;
`ifdef MULT_BCD_EN
  assign bus.bcd     = bcd_r;
  assign bus.bcd_neg = bcd_neg_r;
`endif
endmodule

// File: tb/tb_multiplier_nxm.sv
// Self-checking bench for multiplier_nxm (NA=NB=5); checks bcd/bcd_neg when MULT_BCD_EN is defined.
module tb_multiplier_nxm;
  localparam int NA = 5;
  localparam int NB = 5;
  localparam int W  = NA + NB;
  localparam int D  = (W / 3) + 1;
`ifdef MULT_BCD_EN
  localparam int LAT = NB + 1 + W;
`else
  localparam int LAT = NB + 1;
`endif

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  multiplier_nxm_if #(.NA(NA), .NB(NB)) bus_if ();

  multiplier_nxm #(.NA(NA), .NB(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer product of the interpreted operands, decimal digits of |product|.
  function automatic void model(input logic [NA-1:0] a, input logic [NB-1:0] b, input logic sm,
                                output logic [W-1:0] e_out, output logic [4*D-1:0] e_bcd,
                                output logic e_neg);
    int sa, sb, p, m;
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    p     = sa * sb;
    e_out = p[W-1:0];
    m     = (p < 0) ? -p : p;
    e_bcd = '0;
    for (int d = 0; d < D; d++) begin
      e_bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e_neg = sm & (a[NA-1] ^ b[NB-1]);
  endfunction

  task automatic check_result(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b,
                              input logic sm);
    logic [W-1:0]   e_out;
    logic [4*D-1:0] e_bcd;
    logic           e_neg;
    model(a, b, sm, e_out, e_bcd, e_neg);
    check({tag, "_out"}, 32'(bus_if.out), 32'(e_out));
`ifdef MULT_BCD_EN
    check({tag, "_bcd"}, 32'(bus_if.bcd), 32'(e_bcd));
    check({tag, "_bcd_neg"}, 32'(bus_if.bcd_neg), 32'(e_neg));
`endif
  endtask

  // Called just after the launch edge k; checks latency and the result.
  task automatic finish_op(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b,
                           input logic sm);
    bus_if.a_in        = ~a;
    bus_if.b_in        = ~b;
    bus_if.signed_mode = ~sm;
    check({tag, "_busy_k"}, 32'(bus_if.busy), 32'(1));
    check({tag, "_fin_k"}, 32'(bus_if.finish), 32'(0));
    repeat (LAT - 1) tick();
    check({tag, "_fin_early"}, 32'(bus_if.finish), 32'(0));
    check({tag, "_busy_early"}, 32'(bus_if.busy), 32'(1));
    tick();
    check({tag, "_fin"}, 32'(bus_if.finish), 32'(1));
    check({tag, "_busy_end"}, 32'(bus_if.busy), 32'(0));
    check_result(tag, a, b, sm);
  endtask

  task automatic run_op(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b,
                        input logic sm);
    bus_if.a_in        = a;
    bus_if.b_in        = b;
    bus_if.signed_mode = sm;
    bus_if.start       = 1'b1;
    tick();
    bus_if.start = 1'b0;
    finish_op(tag, a, b, sm);
    tick();
  endtask

  initial begin
    logic [NA-1:0] ra;
    logic [NB-1:0] rb;
    logic          rs;
    tests  = 0;
    failed = 0;
    reset              = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.signed_mode = 1'b0;
    bus_if.a_in        = '0;
    bus_if.b_in        = '0;
    tick();
    tick();
    check("rst_out", 32'(bus_if.out), 32'(0));
    check("rst_finish", 32'(bus_if.finish), 32'(0));
    check("rst_busy", 32'(bus_if.busy), 32'(0));
`ifdef MULT_BCD_EN
    check("rst_bcd", 32'(bus_if.bcd), 32'(0));
    check("rst_bcd_neg", 32'(bus_if.bcd_neg), 32'(0));
`endif
    reset = 1'b0;
    tick();

    run_op("u26x30", 5'd26, 5'd30, 1'b0);
    check("u26x30_const", 32'(bus_if.out), 32'd780);
    run_op("s_m6x3", 5'b11010, 5'b00011, 1'b1);
    check("s_m6x3_const", 32'(bus_if.out), 32'h3EE);
    run_op("s_m16xm16", 5'b10000, 5'b10000, 1'b1);
    check("s_m16xm16_const", 32'(bus_if.out), 32'h100);
    run_op("u31x31", 5'd31, 5'd31, 1'b0);
    check("u31x31_const", 32'(bus_if.out), 32'h3C1);
    run_op("zero", 5'd0, 5'd17, 1'b0);

    // start held high for 20 cycles: exactly one operation
    bus_if.a_in        = 5'd26;
    bus_if.b_in        = 5'd30;
    bus_if.signed_mode = 1'b0;
    bus_if.start       = 1'b1;
    tick();
    check("hold_busy_k", 32'(bus_if.busy), 32'(1));
    repeat (LAT) tick();
    check("hold_fin", 32'(bus_if.finish), 32'(1));
    repeat (20 - LAT) tick();
    check("hold_no_relaunch_fin", 32'(bus_if.finish), 32'(1));
    check("hold_no_relaunch_busy", 32'(bus_if.busy), 32'(0));
    check("hold_out", 32'(bus_if.out), 32'd780);
    bus_if.start = 1'b0;
    tick();

    // new start edge while busy is ignored
    bus_if.a_in  = 5'd7;
    bus_if.b_in  = 5'd9;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (LAT / 2 - 1) tick();
    bus_if.a_in  = 5'd3;
    bus_if.b_in  = 5'd3;
    bus_if.start = 1'b1;
    tick();
    check("ign_busy", 32'(bus_if.busy), 32'(1));
    repeat (LAT - LAT / 2 - 1) tick();
    check("ign_fin_early", 32'(bus_if.finish), 32'(0));
    tick();
    check("ign_fin", 32'(bus_if.finish), 32'(1));
    check("ign_out", 32'(bus_if.out), 32'd63);
    repeat (3) tick();
    check("ign_no_relaunch", 32'(bus_if.busy), 32'(0));
    bus_if.start = 1'b0;
    tick();

    // reset mid-operation
    bus_if.a_in  = 5'd26;
    bus_if.b_in  = 5'd30;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_out", 32'(bus_if.out), 32'(0));
    check("midrst_fin", 32'(bus_if.finish), 32'(0));
    check("midrst_busy", 32'(bus_if.busy), 32'(0));
`ifdef MULT_BCD_EN
    check("midrst_bcd", 32'(bus_if.bcd), 32'(0));
`endif
    reset = 1'b0;
    tick();
    run_op("u13x13", 5'd13, 5'd13, 1'b0);
    check("u13x13_const", 32'(bus_if.out), 32'd169);

    // reset with a start edge in the same cycle: start_q is cleared, so held start launches next
    bus_if.a_in        = 5'd11;
    bus_if.b_in        = 5'd6;
    bus_if.signed_mode = 1'b0;
    bus_if.start       = 1'b1;
    reset              = 1'b1;
    tick();
    check("rststart_busy", 32'(bus_if.busy), 32'(0));
    reset = 1'b0;
    tick();
    bus_if.start = 1'b0;
    finish_op("rststart", 5'd11, 5'd6, 1'b0);
    tick();

    for (int i = 0; i < 12; i++) begin
      ra = NA'($urandom);
      rb = NB'($urandom);
      rs = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
